// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encodings as carried on op_i
//   state_e : control FSM states (IDLE -> CALC -> FIX -> DONE)
//   helpers : decode of the divide and signed bits of an op code
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : 2*WIDTH accumulator
//              mul: {partial product high, multiplier/low product bits}
//              div: {partial remainder, dividend/quotient bits}
//   operand  : multiplicand (mul) or divisor (div), already made non-negative
//   acc_next : accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Partial remainder shifted left, pulling in the next dividend bit.
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand};
        if (is_div) begin
            // diff[WIDTH] is the borrow: set means the divisor did not fit,
            // so the shifted remainder is kept (restored) and a 0 enters.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add becomes the new top bit after the shift.
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   valid_i, op_i  : request and op code, accepted only in IDLE or DONE
//   rs_i, rt_i     : multiplicand/dividend, multiplier/divisor
//   flush_i        : abort an in-flight op; blocks acceptance in IDLE/DONE
//   busy_o         : op in progress (CALC or FIX)
//   done_o         : one-cycle pulse when hi_o/lo_o were just written
//   div_by_zero_o  : qualifies done_o, divisor was zero
//   hi_o, lo_o     : product high/low, or remainder/quotient
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e               state, state_nxt;
    logic                 accept;
    op_e                  op_sel;
    logic                 sgn, rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_abs, rt_abs;

    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc, acc_step;
    logic [WIDTH-1:0]     operand, rs_raw;
    logic                 is_div, neg_lo, neg_hi, dbz_pend;

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done_o = (state == S_DONE);
                if (valid_i && !flush_i) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy_o    = 1'b1;
                state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand conditioning: iterate on magnitudes, remember result signs.
    always_comb begin
        op_sel = op_e'(op_i);
        sgn    = op_is_signed(op_sel);
        rs_neg = sgn && rs_i[WIDTH-1];
        rt_neg = sgn && rt_i[WIDTH-1];
        rs_abs = rs_neg ? -rs_i : rs_i;
        rt_abs = rt_neg ? -rt_i : rt_i;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_step)
    );

    // Sign fix-up. A MULT negates the whole double-width product; a DIV
    // negates quotient and remainder independently (truncating division).
    always_comb begin
        prod = neg_lo ? -acc : acc;
        if (dbz_pend) begin
            fix_hi = rs_raw;
            fix_lo = '1;
        end else if (is_div) begin
            fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt           <= '0;
            acc           <= '0;
            operand       <= '0;
            rs_raw        <= '0;
            is_div        <= 1'b0;
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
            dbz_pend      <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            if (accept) begin
                is_div        <= op_is_div(op_sel);
                cnt           <= CNT_W'(WIDTH);
                rs_raw        <= rs_i;
                neg_lo        <= rs_neg ^ rt_neg;
                neg_hi        <= op_is_div(op_sel) ? rs_neg : (rs_neg ^ rt_neg);
                dbz_pend      <= op_is_div(op_sel) && (rt_i == '0);
                div_by_zero_o <= 1'b0;
                if (op_is_div(op_sel)) begin
                    acc     <= {{WIDTH{1'b0}}, rs_abs};
                    operand <= rt_abs;
                end else begin
                    acc     <= {{WIDTH{1'b0}}, rt_abs};
                    operand <= rs_abs;
                end
            end else if (state == S_CALC) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_FIX && !flush_i) begin
                hi_o          <= fix_hi;
                lo_o          <= fix_lo;
                div_by_zero_o <= dbz_pend;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] rs_i = '0;
    logic [W-1:0] rt_i = '0;
    logic         flush_i = 1'b0;
    logic         busy_o, done_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .op_i          (op_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint      sa, sb, q, r;
        logic [63:0] p, qq, rr;
        sa  = longint'($signed(rs));
        sb  = longint'($signed(rt));
        dbz = 1'b0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, rs} * {32'b0, rt}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (rt == '0) begin
                    dbz = 1'b1; hi = rs; lo = '1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    qq = q; rr = r;
                    hi = rr[31:0]; lo = qq[31:0];
                end else begin
                    hi = rs % rt; lo = rs / rt;
                end
            end
        endcase
    endfunction

    // Caller is before a rising edge; request is accepted at that edge and
    // the task returns at the falling edge of cycle t+1.
    task automatic start(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        valid_i = 1'b1;
        op_i    = op;
        rs_i    = rs;
        rt_i    = rt;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Entered at the falling edge of cycle t+n0; returns at the falling edge
    // of the cycle where done_o is seen (or when the budget runs out).
    task automatic wait_done(input int n0, output int lat, output int bcnt,
                             output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        logic [W-1:0] h0 = hi_o;
        logic [W-1:0] l0 = lo_o;
        int  changes = 0;
        bit  got = 0;
        int  n = n0;
        bcnt = 0;
        lat  = 0;
        while (!got && n <= 80) begin
            if (done_o) begin
                got = 1;
                lat = n;
            end else begin
                if (busy_o) bcnt++;
                if (hi_o !== h0 || lo_o !== l0) changes++;
                @(negedge clk_i);
                n++;
            end
        end
        check("hilo_stable_while_busy", changes, 0);
        check("done_seen", got, 1);
        check("busy_low_in_done", busy_o, 0);
        hi  = hi_o;
        lo  = lo_o;
        dbz = div_by_zero_o;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        int lat, bcnt;
        @(negedge clk_i);
        start(op, rs, rt);
        check("dbz_cleared_on_accept", div_by_zero_o, 0);
        check("busy_after_accept", busy_o, 1);
        wait_done(1, lat, bcnt, hi, lo, dbz);
        check("latency", lat, W + 2);
        check("busy_cycles", bcnt, W + 1);
        @(negedge clk_i);
        check("done_one_pulse", done_o, 0);
    endtask

    initial begin
        logic [W-1:0] hi, lo, ehi, elo, ph, pl;
        logic         dbz, edbz;
        int           lat, bcnt, seen;

        vecs[0] = '{"mult_neg3x5",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1] = '{"multu_max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{"div_neg7_2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{"div_min_m1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4] = '{"divu_by0",     2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{"div_7_neg2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[6] = '{"mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7] = '{"divu_max_16",  2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[8] = '{"div_neg7_by0", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9] = '{"multu_zero",   2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dbz", div_by_zero_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, hi, lo, dbz);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            check({vecs[i].name, "_dbz"}, dbz, vecs[i].dbz);
        end

        // Flush mid-op: no done, hi/lo keep the previous result
        run_op(2'b01, 32'h00000003, 32'h00000007, ph, pl, dbz);
        start(2'b01, 32'hFFFFFFFF, 32'h00000002);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_idle_busy", busy_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(negedge clk_i);
        end
        check("flush_no_done", seen, 0);
        check("flush_hi_kept", hi_o, {32'b0, ph});
        check("flush_lo_kept", lo_o, {32'b0, pl});

        // Flush in IDLE blocks acceptance
        valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_blocks_accept", busy_o, 0);

        // valid_i while busy is ignored, not queued
        start(2'b00, 32'h00000007, 32'hFFFFFFFA);
        repeat (3) @(negedge clk_i);
        valid_i = 1'b1; op_i = 2'b11; rs_i = 32'h1; rt_i = 32'h0;
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_done(5, lat, bcnt, hi, lo, dbz);
        check("ign_latency", lat, W + 2);
        check("ign_hi", hi, 32'hFFFFFFFF);
        check("ign_lo", lo, 32'hFFFFFFD6);
        check("ign_dbz", dbz, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen++;
        end
        check("ign_not_queued", seen, 0);

        // Back-to-back issue from DONE
        @(negedge clk_i);
        start(2'b11, 32'h00000064, 32'h00000007);
        wait_done(1, lat, bcnt, hi, lo, dbz);
        check("b2b_first_lo", lo, 32'd14);
        check("b2b_first_hi", hi, 32'd2);
        start(2'b10, 32'hFFFFFF9C, 32'h00000007);
        check("b2b_accept_busy", busy_o, 1);
        wait_done(1, lat, bcnt, hi, lo, dbz);
        check("b2b_second_latency", lat, W + 2);
        check("b2b_second_lo", lo, 32'hFFFFFFF2);
        check("b2b_second_hi", hi, 32'hFFFFFFFE);
        @(negedge clk_i);

        // Reset mid-op
        start(2'b01, 32'hDEADBEEF, 32'h12345678);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_dbz", div_by_zero_o, 0);
        check("midrst_hi", hi_o, 0);
        check("midrst_lo", lo_o, 0);
        run_op(2'b00, 32'h00001234, 32'hFFFFFFFF, hi, lo, dbz);
        check("post_rst_hi", hi, 32'hFFFFFFFF);
        check("post_rst_lo", lo, 32'hFFFFEDCC);

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'h0;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            model(op, a, b, ehi, elo, edbz);
            run_op(op, a, b, hi, lo, dbz);
            check("rand_hi", hi, ehi);
            check("rand_lo", lo, elo);
            check("rand_dbz", dbz, edbz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
